// File: rtl/seg_scan_if.sv
// Pin-side bundle for seg_scan_controller: display data/config in, anode/segment out.
// The blink_mask member exists only when SEG_SCAN_BLINK_EN is defined.
interface seg_scan_if #(
    parameter int NUM_DIGITS = 8,
    parameter int PWM_BITS   = 4
);
    logic [4*NUM_DIGITS-1:0] data_in;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    load;
    logic [PWM_BITS-1:0]     brightness;
    logic                    blank_lz;
`ifdef SEG_SCAN_BLINK_EN
    logic [NUM_DIGITS-1:0]   blink_mask;
`endif
    logic [NUM_DIGITS-1:0]   anode;
    logic [7:0]              segment;
    logic                    frame_start;
    logic                    load_pending;

    modport master (
`ifdef SEG_SCAN_BLINK_EN
        output blink_mask,
`endif
        output data_in, digit_en, dp_in, load, brightness, blank_lz,
        input  anode, segment, frame_start, load_pending
    );

    modport slave (
`ifdef SEG_SCAN_BLINK_EN
        input  blink_mask,
`endif
        input  data_in, digit_en, dp_in, load, brightness, blank_lz,
        output anode, segment, frame_start, load_pending
    );
endinterface

// File: rtl/seg_scan_controller.sv
// Multiplexed 7-segment scan driver: double-buffered frame-synchronous updates,
// PWM brightness, leading-zero blanking, selectable pin polarity.
// Optional feature macro: SEG_SCAN_BLINK_EN (per-digit blink, parameter BLINK_FRAMES).
module seg_scan_controller #(
    parameter int NUM_DIGITS  = 8,
    parameter int DIGIT_TICKS = 25000,
    parameter int PWM_BITS    = 4,
    parameter int ACTIVE_LOW  = 1
`ifdef SEG_SCAN_BLINK_EN
   ,parameter int BLINK_FRAMES = 64
`endif
) (
    input logic      clk,
    input logic      reset,
    seg_scan_if.slave bus
);
    localparam int TICK_W = $clog2(DIGIT_TICKS);
    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
    localparam logic [7:0]            SEG_OFF = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    logic [TICK_W-1:0]       tick;
    logic [IDX_W-1:0]        idx;
    logic                    tick_tc;
    logic                    boundary;

    logic [4*NUM_DIGITS-1:0] shd_data, act_data;
    logic [NUM_DIGITS-1:0]   shd_en, act_en;
    logic [NUM_DIGITS-1:0]   shd_dp, act_dp;
    logic                    pending;

    logic [NUM_DIGITS-1:0]   anode_q;
    logic [7:0]              segment_q;
    logic                    frame_start_q;

    logic [NUM_DIGITS-1:0]   anode_nxt;
    logic [7:0]              segment_nxt;
    logic [3:0]              cur_nib;
    logic                    cur_blank;
    logic                    pwm_on;
    logic                    lit;

`ifdef SEG_SCAN_BLINK_EN
    localparam int FC_W = $clog2(BLINK_FRAMES + 1);
    logic [NUM_DIGITS-1:0]   shd_mask, act_mask;
    logic [FC_W-1:0]         frame_cnt;
    logic                    blink_off;
`endif

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 7'h3F;  4'h1: seg7 = 7'h06;  4'h2: seg7 = 7'h5B;  4'h3: seg7 = 7'h4F;
            4'h4: seg7 = 7'h66;  4'h5: seg7 = 7'h6D;  4'h6: seg7 = 7'h7D;  4'h7: seg7 = 7'h07;
            4'h8: seg7 = 7'h7F;  4'h9: seg7 = 7'h6F;  4'hA: seg7 = 7'h77;  4'hB: seg7 = 7'h7C;
            4'hC: seg7 = 7'h39;  4'hD: seg7 = 7'h5E;  4'hE: seg7 = 7'h79;  default: seg7 = 7'h71;
        endcase
    endfunction

    assign tick_tc  = (tick == TICK_W'(DIGIT_TICKS - 1));
    assign boundary = tick_tc && (idx == IDX_W'(NUM_DIGITS - 1));

    // Slot timer and digit index; index wraps after the last digit.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick <= '0;
            idx  <= '0;
        end else if (tick_tc) begin
            tick <= '0;
            idx  <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            tick <= tick + 1'b1;
        end
    end

    // Shadow capture on load; active copy only moves at a frame boundary.
    // A load landing on the boundary itself bypasses the shadow.
    always_ff @(posedge clk) begin
        if (reset) begin
            shd_data <= '0;  shd_en <= '0;  shd_dp <= '0;
            act_data <= '0;  act_en <= '0;  act_dp <= '0;
            pending  <= 1'b0;
`ifdef SEG_SCAN_BLINK_EN
            shd_mask <= '0;  act_mask <= '0;
`endif
        end else if (boundary) begin
            if (bus.load) begin
                act_data <= bus.data_in;  act_en <= bus.digit_en;  act_dp <= bus.dp_in;
`ifdef SEG_SCAN_BLINK_EN
                act_mask <= bus.blink_mask;
`endif
            end else if (pending) begin
                act_data <= shd_data;  act_en <= shd_en;  act_dp <= shd_dp;
`ifdef SEG_SCAN_BLINK_EN
                act_mask <= shd_mask;
`endif
            end
            pending <= 1'b0;
        end else if (bus.load) begin
            shd_data <= bus.data_in;  shd_en <= bus.digit_en;  shd_dp <= bus.dp_in;
`ifdef SEG_SCAN_BLINK_EN
            shd_mask <= bus.blink_mask;
`endif
            pending  <= 1'b1;
        end
    end

`ifdef SEG_SCAN_BLINK_EN
    // Blink phase flips every BLINK_FRAMES frame boundaries, starting visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= '0;
            blink_off <= 1'b0;
        end else if (boundary) begin
            if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
                frame_cnt <= '0;
                blink_off <= ~blink_off;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end
`endif

    // Decide whether the current slot lights and what it shows.
    always_comb begin
        cur_nib   = act_data[4*idx +: 4];
        cur_blank = 1'b0;
        if (bus.blank_lz && (idx != '0)) begin
            cur_blank = 1'b1;
            for (int j = 0; j < NUM_DIGITS; j++) begin
                if ((IDX_W'(j) >= idx) && (act_data[4*j +: 4] != 4'd0))
                    cur_blank = 1'b0;
            end
        end
        pwm_on = (bus.brightness == {PWM_BITS{1'b1}}) || (tick[PWM_BITS-1:0] < bus.brightness);
        lit    = act_en[idx] && !cur_blank && pwm_on;
`ifdef SEG_SCAN_BLINK_EN
        if (blink_off && act_mask[idx])
            lit = 1'b0;
`endif
        anode_nxt   = '0;
        segment_nxt = 8'h00;
        if (lit) begin
            anode_nxt   = NUM_DIGITS'(1) << idx;
            segment_nxt = {act_dp[idx], seg7(cur_nib)};
        end
    end

    // Registered pins so anode/segment never glitch; polarity applied here.
    always_ff @(posedge clk) begin
        if (reset) begin
            anode_q       <= AN_OFF;
            segment_q     <= SEG_OFF;
            frame_start_q <= 1'b0;
        end else begin
            anode_q       <= anode_nxt ^ AN_OFF;
            segment_q     <= segment_nxt ^ SEG_OFF;
            frame_start_q <= boundary;
        end
    end

    assign bus.anode        = anode_q;
    assign bus.segment      = segment_q;
    assign bus.frame_start  = frame_start_q;
    assign bus.load_pending = pending;
endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed bench for seg_scan_controller (4 digits, 16 ticks/slot, 2-bit PWM, active-low pins).
module tb_seg_scan_controller;
    localparam int ND = 4;
    localparam int DT = 16;
    localparam int PB = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seg_scan_if #(.NUM_DIGITS(ND), .PWM_BITS(PB)) bus ();

    seg_scan_controller #(
        .NUM_DIGITS(ND), .DIGIT_TICKS(DT), .PWM_BITS(PB), .ACTIVE_LOW(1)
`ifdef SEG_SCAN_BLINK_EN
       ,.BLINK_FRAMES(2)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic set_inputs(input logic [15:0] d, input logic [3:0] en, input logic [3:0] dp);
        bus.data_in  = d;
        bus.digit_en = en;
        bus.dp_in    = dp;
        bus.load     = 1'b1;
    endtask

    // Called on a frame_start sample; walks one whole frame and ends on the next frame_start.
    // exp_seg holds active-high segment bytes, byte s = slot s.
    task automatic check_frame(input string name, input logic [31:0] exp_seg, input logic [3:0] lit_slots,
                               input int phases, input logic exp_lp);
        int s, t;
        logic lit;
        logic [3:0] exp_an;
        logic [7:0] exp_sg;
        for (int o = 1; o <= 64; o++) begin
            @(negedge clk);
            bus.load = 1'b0;
            s = (o - 1) / 16;
            t = (o - 1) % 16;
            lit = lit_slots[s] && ((t % 4) < phases);
            exp_an = lit ? ~(4'b0001 << s) : 4'hF;
            exp_sg = lit ? ~exp_seg[8*s +: 8] : 8'hFF;
            n_checks++;
            if (bus.anode !== exp_an || bus.segment !== exp_sg) begin
                n_fail++;
                $display("FAIL %s pins o=%0d: got anode=%b seg=%h, want anode=%b seg=%h",
                         name, o, bus.anode, bus.segment, exp_an, exp_sg);
            end
            n_checks++;
            if (bus.frame_start !== (o == 64)) begin
                n_fail++;
                $display("FAIL %s frame_start o=%0d: got %b, want %b", name, o, bus.frame_start, (o == 64));
            end
            n_checks++;
            if (bus.load_pending !== ((o == 64) ? 1'b0 : exp_lp)) begin
                n_fail++;
                $display("FAIL %s load_pending o=%0d: got %b, want %b", name, o, bus.load_pending,
                         ((o == 64) ? 1'b0 : exp_lp));
            end
        end
    endtask

    // Starts right after reset release with a load pulse driven; display must stay dark.
    task automatic test_first_frame(input string name, input logic exp_lp);
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            bus.load = 1'b0;
            n_checks++;
            if (bus.anode !== 4'hF || bus.segment !== 8'hFF) begin
                n_fail++;
                $display("FAIL %s dark k=%0d: got anode=%b seg=%h, want 1111/ff", name, k, bus.anode, bus.segment);
            end
            n_checks++;
            if (bus.frame_start !== (k == 64)) begin
                n_fail++;
                $display("FAIL %s frame_start k=%0d: got %b, want %b", name, k, bus.frame_start, (k == 64));
            end
            n_checks++;
            if (bus.load_pending !== ((k < 64) ? exp_lp : 1'b0)) begin
                n_fail++;
                $display("FAIL %s load_pending k=%0d: got %b", name, k, bus.load_pending);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.anode !== 4'hF || bus.segment !== 8'hFF) begin
            n_fail++;
            $display("FAIL reset pins: got anode=%b seg=%h, want 1111/ff", bus.anode, bus.segment);
        end
        n_checks++;
        if (bus.frame_start !== 1'b0 || bus.load_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL reset flags: got fs=%b lp=%b, want 0/0", bus.frame_start, bus.load_pending);
        end
        reset = 1'b0;
        set_inputs(16'h1234, 4'hF, 4'h0);
        test_first_frame("first_frame", 1'b1);
    endtask

    task automatic test_display();
        check_frame("digits_1234", 32'h065B4F66, 4'hF, 4, 1'b0);
    endtask

    task automatic test_pwm();
        bus.brightness = 2'd1;
        check_frame("brt1", 32'h065B4F66, 4'hF, 1, 1'b0);
        bus.brightness = 2'd0;
        check_frame("brt0", 32'h065B4F66, 4'hF, 0, 1'b0);
        bus.brightness = 2'd3;
    endtask

    task automatic test_blank();
        bus.blank_lz = 1'b1;
        set_inputs(16'h0005, 4'hF, 4'hF);
        check_frame("blank_old", 32'h065B4F66, 4'hF, 4, 1'b1);
        check_frame("blank_5", 32'h000000ED, 4'h1, 4, 1'b0);
        set_inputs(16'h0000, 4'hF, 4'h0);
        check_frame("zero_old", 32'h000000ED, 4'h1, 4, 1'b1);
        check_frame("zero", 32'h0000003F, 4'h1, 4, 1'b0);
    endtask

    task automatic test_no_tear();
        logic [3:0] exp_an;
        logic [7:0] exp_sg;
        set_inputs(16'hAAAA, 4'hF, 4'h0);
        for (int o = 1; o <= 64; o++) begin
            @(negedge clk);
            bus.load = 1'b0;
            if (o == 20) set_inputs(16'hBBBB, 4'hF, 4'h0);
            exp_an = (o <= 16) ? 4'b1110 : 4'hF;
            exp_sg = (o <= 16) ? ~8'h3F : 8'hFF;
            n_checks++;
            if (bus.anode !== exp_an || bus.segment !== exp_sg) begin
                n_fail++;
                $display("FAIL no_tear pins o=%0d: got anode=%b seg=%h, want %b/%h", o, bus.anode, bus.segment, exp_an, exp_sg);
            end
            n_checks++;
            if (bus.load_pending !== (o < 64)) begin
                n_fail++;
                $display("FAIL no_tear load_pending o=%0d: got %b, want %b", o, bus.load_pending, (o < 64));
            end
        end
        check_frame("bbbb", 32'h7C7C7C7C, 4'hF, 4, 1'b0);
    endtask

    task automatic test_boundary_load();
        int s;
        for (int o = 1; o <= 64; o++) begin
            @(negedge clk);
            bus.load = 1'b0;
            s = (o - 1) / 16;
            n_checks++;
            if (bus.anode !== ~(4'b0001 << s) || bus.segment !== ~8'h7C) begin
                n_fail++;
                $display("FAIL bnd_pre pins o=%0d: got anode=%b seg=%h", o, bus.anode, bus.segment);
            end
            n_checks++;
            if (bus.load_pending !== 1'b0 || bus.frame_start !== (o == 64)) begin
                n_fail++;
                $display("FAIL bnd_pre flags o=%0d: got lp=%b fs=%b", o, bus.load_pending, bus.frame_start);
            end
            if (o == 63) set_inputs(16'h00C0, 4'hE, 4'h0);
        end
        check_frame("bnd_load", 32'h00003900, 4'b0010, 4, 1'b0);
    endtask

    task automatic test_reset_mid();
        set_inputs(16'h1234, 4'hF, 4'h0);
        repeat (20) begin
            @(negedge clk);
            bus.load = 1'b0;
        end
        n_checks++;
        if (bus.anode !== 4'b1101 || bus.segment !== ~8'h39 || bus.load_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid pre: got anode=%b seg=%h lp=%b, want 1101/c6/1", bus.anode, bus.segment, bus.load_pending);
        end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.anode !== 4'hF || bus.segment !== 8'hFF || bus.load_pending !== 1'b0 || bus.frame_start !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid post: got anode=%b seg=%h lp=%b fs=%b", bus.anode, bus.segment, bus.load_pending, bus.frame_start);
        end
        reset = 1'b0;
        test_first_frame("rst_mid_frame", 1'b0);
    endtask

`ifdef SEG_SCAN_BLINK_EN
    task automatic test_blink();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bus.blank_lz = 1'b0;
        bus.blink_mask = 4'b0001;
        set_inputs(16'h1234, 4'hF, 4'h0);
        test_first_frame("blink_first", 1'b1);
        check_frame("blink_on1", 32'h065B4F66, 4'hF, 4, 1'b0);
        check_frame("blink_off1", 32'h065B4F66, 4'hE, 4, 1'b0);
        check_frame("blink_off2", 32'h065B4F66, 4'hE, 4, 1'b0);
        check_frame("blink_on2", 32'h065B4F66, 4'hF, 4, 1'b0);
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        bus.data_in    = '0;
        bus.digit_en   = '0;
        bus.dp_in      = '0;
        bus.load       = 1'b0;
        bus.brightness = 2'd3;
        bus.blank_lz   = 1'b0;
`ifdef SEG_SCAN_BLINK_EN
        bus.blink_mask = '0;
`endif
        test_reset();
        test_display();
        test_pwm();
        test_blank();
        test_no_tear();
        test_boundary_load();
        test_reset_mid();
`ifdef SEG_SCAN_BLINK_EN
        test_blink();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
